// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared constants and entry type for the forwarding scoreboard
//
// Purpose: forward-selector encoding, post-EX stage indices and the
// in-flight entry record shared by fwd_scoreboard and fwd_match.
package mycpu_pkg;

  // Selector value meaning "read the register file"; entries encode as
  // 1 + stage*LANES + lane.
  localparam int FWD_RF = 0;

  // Post-EX stage indices.
  localparam int STG_M1 = 0;
  localparam int STG_M2 = 1;
  localparam int STG_WB = 2;

  // Byte mask of a full-word write.
  localparam logic [3:0] WEN_FULL = 4'b1111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] rdy_stage;
    logic [3:0] wen;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest-match forward search for one source register
//
// Purpose: scans the scoreboard entry array for the youngest valid writer of
// one source register and reports its selector, byte mask and hazard.
// Ports:
//   entries : flattened entry array, index stage*LANES+lane
//   src     : source register number
//   sel     : FWD_RF or 1+stage*LANES+lane of the youngest match
//   wen     : byte mask of the forwarded value (4'b1111 if none)
//   stall   : youngest match is not yet forwardable
// Macro FWD_PARTIAL_WEN_EN: partial-mask writers forward from the last stage.
module fwd_match
  import mycpu_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int SELW   = 1 + $clog2(LANES * STAGES)
) (
  input  fwd_entry_t [STAGES*LANES-1:0] entries,
  input  logic [4:0]                    src,
  output logic [SELW-1:0]               sel,
  output logic [3:0]                    wen,
  output logic                          stall
);

  logic found;

  // Stage 0 is youngest; inside a stage the highest lane issued last, so
  // lanes are scanned downwards and the first hit wins.
  always_comb begin
    sel   = SELW'(FWD_RF);
    wen   = WEN_FULL;
    stall = 1'b0;
    found = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      for (int l = LANES - 1; l >= 0; l--) begin
        if (!found && src != 5'd0 && entries[s*LANES+l].valid &&
            entries[s*LANES+l].rd == src) begin
          found = 1'b1;
          sel   = SELW'(1 + s * LANES + l);
          if (int'(entries[s*LANES+l].rdy_stage) > s) begin
            stall = 1'b1;
          end
`ifdef FWD_PARTIAL_WEN_EN
          wen = entries[s*LANES+l].wen;
          // A partial value can only be merged once it reaches the last stage.
          if (entries[s*LANES+l].wen != WEN_FULL && s != STAGES - 1) begin
            stall = 1'b1;
          end
`else
          // No merge path: wait until the partial writer leaves the array.
          if (entries[s*LANES+l].wen != WEN_FULL) begin
            stall = 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - post-EX result tracking and operand forward selection
//
// Purpose: tracks STAGES x LANES in-flight register writers and, for each of
// the two sources of every decode lane, selects the forwarding source and
// raises a load-use / partial-write stall.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   iss_*          : per-lane issue into EX (valid, reg_write, rd, rdy_stage, wen)
//   pipe_adv       : shift the entry array one stage
//   flush          : invalidate all entries
//   ds_src         : decode sources, lane l rs1 at [10l+:5], rs2 at [10l+5+:5]
//   fwd_sel        : per-source selector, source k=2*lane+n at [k*SELW+:SELW]
//   fwd_wen        : per-source byte mask at [4k+:4]
//   stall          : decode group must hold
// Macro FWD_PARTIAL_WEN_EN: enable forwarding of partial-mask writes from the
// last stage (default build stalls on them and drives fwd_wen all ones).
// Same-group lane0->lane1 dependencies are left to the issue logic.
module fwd_scoreboard
  import mycpu_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int SELW   = 1 + $clog2(LANES * STAGES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANES-1:0]         iss_valid,
  input  logic [LANES-1:0]         iss_reg_write,
  input  logic [5*LANES-1:0]       iss_rd,
  input  logic [2*LANES-1:0]       iss_rdy_stage,
  input  logic [4*LANES-1:0]       iss_wen,
  input  logic                     pipe_adv,
  input  logic                     flush,
  input  logic [10*LANES-1:0]      ds_src,
  output logic [2*LANES*SELW-1:0]  fwd_sel,
  output logic [8*LANES-1:0]       fwd_wen,
  output logic                     stall
);

  fwd_entry_t [STAGES*LANES-1:0] ent_q;
  logic       [2*LANES-1:0]      src_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES * LANES; i++) begin
        ent_q[i].valid <= 1'b0;
      end
    end else if (pipe_adv) begin
      for (int s = STAGES - 1; s > 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          ent_q[s*LANES+l] <= ent_q[(s-1)*LANES+l];
        end
      end
      for (int l = 0; l < LANES; l++) begin
        ent_q[l].valid     <= iss_valid[l] & iss_reg_write[l];
        ent_q[l].rd        <= iss_rd[5*l +: 5];
        ent_q[l].rdy_stage <= iss_rdy_stage[2*l +: 2];
        ent_q[l].wen       <= iss_wen[4*l +: 4];
      end
    end
  end

  for (genvar k = 0; k < 2 * LANES; k++) begin : g_src
    fwd_match #(
      .LANES (LANES),
      .STAGES(STAGES),
      .SELW  (SELW)
    ) u_match (
      .entries(ent_q),
      .src    (ds_src[5*k +: 5]),
      .sel    (fwd_sel[k*SELW +: SELW]),
      .wen    (fwd_wen[4*k +: 4]),
      .stall  (src_stall[k])
    );
  end

  assign stall = |src_stall;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed table-driven bench for fwd_scoreboard
module tb_fwd_scoreboard;

  localparam int LANES  = 2;
  localparam int STAGES = 3;
  localparam int SELW   = 1 + $clog2(LANES * STAGES);
  localparam logic [15:0] WF = 16'hFFFF;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LANES-1:0]        iss_valid;
  logic [LANES-1:0]        iss_reg_write;
  logic [5*LANES-1:0]      iss_rd;
  logic [2*LANES-1:0]      iss_rdy_stage;
  logic [4*LANES-1:0]      iss_wen;
  logic                    pipe_adv;
  logic                    flush;
  logic [10*LANES-1:0]     ds_src;
  logic [2*LANES*SELW-1:0] fwd_sel;
  logic [8*LANES-1:0]      fwd_wen;
  logic                    stall;

  always #5 clk = ~clk;

  fwd_scoreboard #(.LANES(LANES), .STAGES(STAGES), .SELW(SELW)) dut (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_reg_write(iss_reg_write),
    .iss_rd       (iss_rd),
    .iss_rdy_stage(iss_rdy_stage),
    .iss_wen      (iss_wen),
    .pipe_adv     (pipe_adv),
    .flush        (flush),
    .ds_src       (ds_src),
    .fwd_sel      (fwd_sel),
    .fwd_wen      (fwd_wen),
    .stall        (stall)
  );

  // Inputs are applied for one cycle; expectations describe the outputs
  // during that cycle, i.e. before its closing edge commits the controls.
  typedef struct {
    logic        rst;
    logic        fl;
    logic        adv;
    logic [1:0]  iv;
    logic [1:0]  rw;
    logic [9:0]  rd;
    logic [3:0]  rdy;
    logic [7:0]  wen;
    logic [19:0] src;
    logic [15:0] esel;
    logic [15:0] ewen;
    logic        est;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [19:0] src4(logic [4:0] a, logic [4:0] b,
                                       logic [4:0] c, logic [4:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0] q4(logic [3:0] a, logic [3:0] b,
                                     logic [3:0] c, logic [3:0] d);
    return {d, c, b, a};
  endfunction

  task automatic add(input logic rst, input logic fl, input logic adv,
                     input logic [1:0] iv, input logic [1:0] rw,
                     input logic [4:0] rd0, input logic [4:0] rd1,
                     input logic [1:0] rdy0, input logic [3:0] wen0,
                     input logic [19:0] src, input logic [15:0] esel,
                     input logic [15:0] ewen, input logic est);
    vec_t v;
    v.rst = rst; v.fl = fl; v.adv = adv; v.iv = iv; v.rw = rw;
    v.rd = {rd1, rd0}; v.rdy = {2'd0, rdy0}; v.wen = {4'hF, wen0};
    v.src = src; v.esel = esel; v.ewen = ewen; v.est = est;
    vq.push_back(v);
  endtask

`ifdef FWD_PARTIAL_WEN_EN
  localparam logic [15:0] PW_EARLY = 16'hFFF3;
  localparam logic [15:0] PW_LAST  = 16'hFFF3;
  localparam logic        PST_LAST = 1'b0;
`else
  localparam logic [15:0] PW_EARLY = 16'hFFFF;
  localparam logic [15:0] PW_LAST  = 16'hFFFF;
  localparam logic        PST_LAST = 1'b1;
`endif

  initial begin
    logic [19:0] s12;
    s12 = src4(12, 0, 0, 0);
    //  rst fl adv iv     rw     rd0 rd1 rdy wen0     src                esel              ewen      st
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(5, 6, 7, 8), '0,               WF,       0);
    add(0, 0, 1, 2'b01, 2'b01, 5,  0,  0, 4'hF, src4(5, 0, 0, 0), '0,               WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(5, 0, 0, 0), q4(1, 0, 0, 0),   WF,       0);
    add(0, 1, 1, 2'b11, 2'b11, 3,  4,  0, 4'hF, src4(5, 0, 0, 0), q4(1, 0, 0, 0),   WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(3, 4, 5, 0), '0,               WF,       0);
    add(0, 0, 1, 2'b01, 2'b01, 8,  0,  1, 4'hF, '0,               '0,               WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(8, 0, 0, 0), q4(1, 0, 0, 0),   WF,       1);
    add(0, 0, 1, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(8, 0, 0, 0), q4(1, 0, 0, 0),   WF,       1);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(0, 0, 8, 0), q4(0, 0, 3, 0),   WF,       0);
    add(0, 0, 1, 2'b10, 2'b10, 0,  9,  0, 4'hF, '0,               '0,               WF,       0);
    add(0, 0, 1, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(8, 9, 0, 0), q4(5, 2, 0, 0),   WF,       0);
    add(0, 0, 1, 2'b11, 2'b11, 9,  0,  0, 4'hF, src4(0, 0, 9, 0), q4(0, 0, 4, 0),   WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(9, 0, 9, 0), q4(1, 0, 1, 0),   WF,       0);
    add(0, 0, 1, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(9, 0, 9, 0), q4(1, 0, 1, 0),   WF,       0);
    add(0, 0, 1, 2'b11, 2'b01, 12, 12, 0, 4'h3, '0,               '0,               WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, s12,              q4(1, 0, 0, 0),   PW_EARLY, 1);
    add(0, 0, 1, 2'b00, 2'b00, 0,  0,  0, 4'hF, s12,              q4(1, 0, 0, 0),   PW_EARLY, 1);
    add(0, 0, 1, 2'b00, 2'b00, 0,  0,  0, 4'hF, s12,              q4(3, 0, 0, 0),   PW_EARLY, 1);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, s12,              q4(5, 0, 0, 0),   PW_LAST,  PST_LAST);
    add(0, 0, 1, 2'b00, 2'b00, 0,  0,  0, 4'hF, s12,              q4(5, 0, 0, 0),   PW_LAST,  PST_LAST);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, s12,              '0,               WF,       0);
    add(1, 1, 1, 2'b01, 2'b01, 7,  0,  0, 4'hF, src4(7, 0, 0, 0), '0,               WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(7, 0, 0, 0), '0,               WF,       0);
    add(0, 0, 1, 2'b11, 2'b11, 10, 10, 0, 4'hF, '0,               '0,               WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(0, 0, 0, 10), q4(0, 0, 0, 2),  WF,       0);
    add(0, 1, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(0, 0, 0, 10), q4(0, 0, 0, 2),  WF,       0);
    add(0, 0, 0, 2'b00, 2'b00, 0,  0,  0, 4'hF, src4(0, 0, 0, 10), '0,              WF,       0);

    reset = 1'b1; flush = 1'b0; pipe_adv = 1'b0;
    iss_valid = '0; iss_reg_write = '0; iss_rd = '0;
    iss_rdy_stage = '0; iss_wen = '1; ds_src = '0;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      reset         = vq[i].rst;
      flush         = vq[i].fl;
      pipe_adv      = vq[i].adv;
      iss_valid     = vq[i].iv;
      iss_reg_write = vq[i].rw;
      iss_rd        = vq[i].rd;
      iss_rdy_stage = vq[i].rdy;
      iss_wen       = vq[i].wen;
      ds_src        = vq[i].src;
      @(negedge clk);
      n_tests++;
      if (fwd_sel !== vq[i].esel) begin
        n_fail++;
        $display("FAIL row%0d fwd_sel: got %h expected %h", i, fwd_sel, vq[i].esel);
      end
      n_tests++;
      if (fwd_wen !== vq[i].ewen) begin
        n_fail++;
        $display("FAIL row%0d fwd_wen: got %h expected %h", i, fwd_wen, vq[i].ewen);
      end
      n_tests++;
      if (stall !== vq[i].est) begin
        n_fail++;
        $display("FAIL row%0d stall: got %b expected %b", i, stall, vq[i].est);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
